spm_serial_mult: RTL



---
 rtl/spm_serial_mult_if.sv | 28 ++
 rtl/spm_serial_mult.sv | 137 +++++++++++++
 2 files changed

// File: rtl/spm_serial_mult_if.sv
// rtl/spm_serial_mult_if.sv - operand/product handshake bundle for spm_serial_mult
interface spm_serial_mult_if #(
    parameter int WIDTH = 8,
    parameter int YBITS = 8
);
    localparam int P = WIDTH + YBITS;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [YBITS-1:0] y;
    logic             sbit_valid;
    logic             sbit;
    logic             sbit_last;
    logic             out_valid;
    logic             out_ready;
    logic [P-1:0]     prod;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, sbit_valid, sbit, sbit_last, out_valid, prod
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, sbit_valid, sbit, sbit_last, out_valid, prod
    );
endinterface

// File: rtl/spm_serial_mult.sv
// rtl/spm_serial_mult.sv - serial-parallel csa-chain multiplier, LSB-first product stream
// Define SPM_SIGNED_EN for two's complement operands (Baugh-Wooley top cell).
module spm_serial_mult #(
    parameter int WIDTH = 8,
    parameter int YBITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    spm_serial_mult_if.slave  bus
);
    localparam int P     = WIDTH + YBITS;
    localparam int CNT_W = $clog2(P + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:1] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] s_up;
    logic [WIDTH-1:0] sum_n;
    logic [WIDTH-1:0] carry_n;
    logic [YBITS-1:0] y_sh;
    logic [YBITS-1:0] y_next;
    logic [CNT_W-1:0] cnt;
    logic [P-1:0]     prod_r;
    logic [P-1:0]     bit_sel;
    logic             ybit;
    logic             top_in;
    logic             cnt_last;
    logic             accept;
    logic             running;
    logic             in_ready_c;
    logic             sbit_valid_c;
    logic             sbit_c;
    logic             sbit_last_c;
    logic             out_valid_c;

    assign ybit     = y_sh[0];
    assign cnt_last = (cnt == CNT_W'(P - 1));
    assign bit_sel  = P'(1) << cnt;

`ifdef SPM_SIGNED_EN
    localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [YBITS-1:0] Y_MSB   = YBITS'(1) << (YBITS - 1);
    // Top cell adds ~(x*y) instead of -(x*y); the 2^(WIDTH-1) injected on the
    // first cycle absorbs the resulting constant modulo 2^P.
    assign a      = (x_r & {WIDTH{ybit}}) ^ TOP_BIT;
    assign top_in = (cnt == '0);
    assign y_next = (y_sh >> 1) | (y_sh & Y_MSB);
`else
    assign a      = x_r & {WIDTH{ybit}};
    assign top_in = 1'b0;
    assign y_next = y_sh >> 1;
`endif

    // Cell i sees the sum of cell i+1 from the previous cycle (same weight).
    assign s_up    = {top_in, s};
    assign sum_n   = a ^ s_up ^ c;
    assign carry_n = (a & s_up) | (a & c) | (s_up & c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        running      = 1'b0;
        in_ready_c   = 1'b0;
        sbit_valid_c = 1'b0;
        sbit_c       = 1'b0;
        sbit_last_c  = 1'b0;
        out_valid_c  = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                running      = 1'b1;
                sbit_valid_c = 1'b1;
                sbit_c       = sum_n[0];
                sbit_last_c  = cnt_last;
                if (cnt_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= '0;
            y_sh   <= '0;
            s      <= '0;
            c      <= '0;
            cnt    <= '0;
            prod_r <= '0;
        end else if (accept) begin
            x_r  <= bus.x;
            y_sh <= bus.y;
            s    <= '0;
            c    <= '0;
            cnt  <= '0;
        end else if (running) begin
            s      <= sum_n[WIDTH-1:1];
            c      <= carry_n;
            y_sh   <= y_next;
            cnt    <= cnt + CNT_W'(1);
            prod_r <= (prod_r & ~bit_sel) | (sum_n[0] ? bit_sel : '0);
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.sbit_valid = sbit_valid_c;
    assign bus.sbit       = sbit_c;
    assign bus.sbit_last  = sbit_last_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.prod       = prod_r;
endmodule
